// File: rtl/trax_autocomplete_engine.sv
// Trax forced-move engine: sweeps the active board region row-major, fills
// every empty cell whose neighbour edges force a tile, and repeats passes until
// a pass writes nothing. Flags cells with three or more same-colour edges.
module trax_autocomplete_engine #(
  parameter int ROWS       = 20,
  parameter int COLS       = 20,
  parameter int ADDR_W     = 9,
  parameter int MAX_PASSES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        n,
  input  logic [9:0]        m,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [2:0]        mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [2:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [9:0]        fill_count,
  output logic              conflict,
  output logic [9:0]        conflict_row,
  output logic [9:0]        conflict_col,
  output logic              pass_overflow
);

  localparam int PASS_W = $clog2(MAX_PASSES + 1);

  localparam logic [1:0] T_PLUS   = 2'b01;
  localparam logic [1:0] T_SLASH  = 2'b10;
  localparam logic [1:0] T_BSLASH = 2'b11;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_RCUR = 4'd1;
  localparam logic [3:0] S_CCUR = 4'd2;
  localparam logic [3:0] S_RUP  = 4'd3;
  localparam logic [3:0] S_RDN  = 4'd4;
  localparam logic [3:0] S_RLF  = 4'd5;
  localparam logic [3:0] S_RRT  = 4'd6;
  localparam logic [3:0] S_EVAL = 4'd7;
  localparam logic [3:0] S_WR   = 4'd8;
  localparam logic [3:0] S_NEXT = 4'd9;
  localparam logic [3:0] S_PEND = 4'd10;
  localparam logic [3:0] S_DONE = 4'd11;

  logic [3:0]        state_r;
  logic [9:0]        row_r, col_r, n_r, m_r;
  logic [PASS_W-1:0] pass_r;
  logic              pass_changed_r;
  logic [2:0]        up_tile_r, dn_tile_r, lf_tile_r;

  logic [ADDR_W-1:0] cur_addr_s, up_addr_s, dn_addr_s, lf_addr_s, rt_addr_s, nxt_addr_s;
  logic              up_ok_s, dn_ok_s, lf_ok_s, rt_ok_s, last_cell_s;
  logic [9:0]        nxt_row_s, nxt_col_s;
  logic [2:0]        rt_tile_s;
  logic [1:0]        eu_s, ed_s, el_s, er_s;
  logic [2:0]        ones_s, zeros_s;
  logic              conflict_s, forced_s;
  logic [2:0]        force_tile_s;

  // Physical RAM address of a board cell (row-major, COLS wide).
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] r, input logic [9:0] c);
    logic [31:0] a;
    a = {22'd0, r} * 32'(COLS) + {22'd0, c};
    return a[ADDR_W-1:0];
  endfunction

  // Edge a neighbour presents to the cell: {known, colour}. 'direct' means
  // the colour passes through unchanged for every tile type.
  function automatic logic [1:0] edge_of(input logic [2:0] tile, input logic [1:0] pass_type,
                                         input logic direct);
    logic [1:0] e;
    if (tile[2:1] == 2'b00) begin
      e = 2'b00;
    end else if (direct || (tile[2:1] == pass_type)) begin
      e = {1'b1, tile[0]};
    end else begin
      e = {1'b1, ~tile[0]};
    end
    return e;
  endfunction

  // Scan position, neighbour addresses and range checks for the current cell.
  always_comb begin
    cur_addr_s  = cell_addr(row_r, col_r);
    up_addr_s   = cell_addr(row_r - 10'd1, col_r);
    dn_addr_s   = cell_addr(row_r + 10'd1, col_r);
    lf_addr_s   = cell_addr(row_r, col_r - 10'd1);
    rt_addr_s   = cell_addr(row_r, col_r + 10'd1);
    up_ok_s     = (row_r != 10'd0);
    dn_ok_s     = ((row_r + 10'd1) < n_r);
    lf_ok_s     = (col_r != 10'd0);
    rt_ok_s     = ((col_r + 10'd1) < m_r);
    nxt_row_s   = row_r;
    nxt_col_s   = col_r + 10'd1;
    last_cell_s = 1'b0;
    if ((col_r + 10'd1) >= m_r) begin
      nxt_col_s = 10'd0;
      if ((row_r + 10'd1) >= n_r) begin
        nxt_row_s   = 10'd0;
        last_cell_s = 1'b1;
      end else begin
        nxt_row_s = row_r + 10'd1;
      end
    end else begin
      nxt_col_s = col_r + 10'd1;
    end
    nxt_addr_s = cell_addr(nxt_row_s, nxt_col_s);
  end

  // Edge colours, conflict detection and forced-tile selection (right datum arrives in EVAL).
  always_comb begin
    rt_tile_s = rt_ok_s ? mem_rdata : 3'b000;
    eu_s = edge_of(up_tile_r, T_PLUS, 1'b0);
    ed_s = edge_of(dn_tile_r, T_PLUS, 1'b1);
    el_s = edge_of(lf_tile_r, T_BSLASH, 1'b0);
    er_s = edge_of(rt_tile_s, T_SLASH, 1'b0);
    ones_s  = {2'b00, eu_s[1] & eu_s[0]} + {2'b00, ed_s[1] & ed_s[0]}
            + {2'b00, el_s[1] & el_s[0]} + {2'b00, er_s[1] & er_s[0]};
    zeros_s = {2'b00, eu_s[1] & ~eu_s[0]} + {2'b00, ed_s[1] & ~ed_s[0]}
            + {2'b00, el_s[1] & ~el_s[0]} + {2'b00, er_s[1] & ~er_s[0]};
    conflict_s   = (ones_s >= 3'd3) || (zeros_s >= 3'd3);
    forced_s     = 1'b1;
    force_tile_s = 3'b000;
    if (eu_s[1] && er_s[1] && (eu_s[0] == er_s[0])) begin
      force_tile_s = {T_BSLASH, eu_s[0]};
    end else if (eu_s[1] && ed_s[1] && (eu_s[0] == ed_s[0])) begin
      force_tile_s = {T_PLUS, eu_s[0]};
    end else if (eu_s[1] && el_s[1] && (eu_s[0] == el_s[0])) begin
      force_tile_s = {T_SLASH, eu_s[0]};
    end else if (er_s[1] && ed_s[1] && (er_s[0] == ed_s[0])) begin
      force_tile_s = {T_SLASH, ~er_s[0]};
    end else if (er_s[1] && el_s[1] && (er_s[0] == el_s[0])) begin
      force_tile_s = {T_PLUS, ~er_s[0]};
    end else if (ed_s[1] && el_s[1] && (ed_s[0] == el_s[0])) begin
      force_tile_s = {T_BSLASH, ~ed_s[0]};
    end else begin
      forced_s = 1'b0;
    end
    if (conflict_s) begin
      forced_s = 1'b0;
    end else begin
      forced_s = forced_s;
    end
  end

  // Sweep FSM: sequences reads, writes forced tiles, and keeps per-run status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      row_r          <= 10'd0;
      col_r          <= 10'd0;
      n_r            <= 10'd0;
      m_r            <= 10'd0;
      pass_r         <= '0;
      pass_changed_r <= 1'b0;
      up_tile_r      <= 3'b000;
      dn_tile_r      <= 3'b000;
      lf_tile_r      <= 3'b000;
      mem_raddr      <= '0;
      mem_we         <= 1'b0;
      mem_waddr      <= '0;
      mem_wdata      <= 3'b000;
      busy           <= 1'b0;
      done           <= 1'b0;
      fill_count     <= 10'd0;
      conflict       <= 1'b0;
      conflict_row   <= 10'd0;
      conflict_col   <= 10'd0;
      pass_overflow  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_r            <= (n > 10'(ROWS)) ? 10'(ROWS) : n;
            m_r            <= (m > 10'(COLS)) ? 10'(COLS) : m;
            row_r          <= 10'd0;
            col_r          <= 10'd0;
            pass_r         <= '0;
            pass_changed_r <= 1'b0;
            fill_count     <= 10'd0;
            conflict       <= 1'b0;
            conflict_row   <= 10'd0;
            conflict_col   <= 10'd0;
            pass_overflow  <= 1'b0;
            busy           <= 1'b1;
            mem_raddr      <= '0;
            state_r        <= ((n == 10'd0) || (m == 10'd0)) ? S_PEND : S_RCUR;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_RCUR: state_r <= S_CCUR;
        S_CCUR: begin
          if (mem_rdata[2:1] != 2'b00) begin
            state_r <= S_NEXT;
          end else begin
            if (up_ok_s) mem_raddr <= up_addr_s;
            state_r <= S_RUP;
          end
        end
        S_RUP: begin
          if (dn_ok_s) mem_raddr <= dn_addr_s;
          state_r <= S_RDN;
        end
        S_RDN: begin
          up_tile_r <= up_ok_s ? mem_rdata : 3'b000;
          if (lf_ok_s) mem_raddr <= lf_addr_s;
          state_r <= S_RLF;
        end
        S_RLF: begin
          dn_tile_r <= dn_ok_s ? mem_rdata : 3'b000;
          if (rt_ok_s) mem_raddr <= rt_addr_s;
          state_r <= S_RRT;
        end
        S_RRT: begin
          lf_tile_r <= lf_ok_s ? mem_rdata : 3'b000;
          state_r   <= S_EVAL;
        end
        S_EVAL: begin
          if (forced_s) begin
            mem_we    <= 1'b1;
            mem_waddr <= cur_addr_s;
            mem_wdata <= force_tile_s;
            state_r   <= S_WR;
          end else begin
            if (conflict_s && !conflict) begin
              conflict     <= 1'b1;
              conflict_row <= row_r;
              conflict_col <= col_r;
            end
            state_r <= S_NEXT;
          end
        end
        S_WR: begin
          mem_we         <= 1'b0;
          pass_changed_r <= 1'b1;
          if (fill_count != 10'h3FF) fill_count <= fill_count + 10'd1;
          state_r <= S_NEXT;
        end
        S_NEXT: begin
          row_r <= nxt_row_s;
          col_r <= nxt_col_s;
          if (last_cell_s) begin
            state_r <= S_PEND;
          end else begin
            mem_raddr <= nxt_addr_s;
            state_r   <= S_RCUR;
          end
        end
        S_PEND: begin
          if (pass_changed_r) begin
            pass_changed_r <= 1'b0;
            if (pass_r == PASS_W'(MAX_PASSES - 1)) begin
              pass_overflow <= 1'b1;
              busy          <= 1'b0;
              done          <= 1'b1;
              state_r       <= S_DONE;
            end else begin
              pass_r    <= pass_r + 1'b1;
              row_r     <= 10'd0;
              col_r     <= 10'd0;
              mem_raddr <= '0;
              state_r   <= S_RCUR;
            end
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trax_autocomplete_engine.sv
// Directed bench for trax_autocomplete_engine: two instances (default pass
// limit and a pass limit of 2), each with its own synchronous board RAM model.
module tb_trax_autocomplete_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [9:0] n_in, m_in;
  logic [8:0] raddr0, raddr1, waddr0, waddr1;
  logic [2:0] rdata0, rdata1, wdata0, wdata1;
  logic       we0, we1, busy0, busy1, done0, done1, conf0, conf1, ovf0, ovf1;
  logic [9:0] fill0, fill1, crow0, crow1, ccol0, ccol1;

  logic [2:0] mem0 [512];
  logic [2:0] mem1 [512];
  logic       tb_we;
  logic [8:0] tb_waddr;
  logic [2:0] tb_wdata;
  int         we_cnt0 = 0;
  int         we_cnt1 = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  trax_autocomplete_engine #(.ROWS(20), .COLS(20), .ADDR_W(9), .MAX_PASSES(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .n(n_in), .m(m_in),
    .mem_raddr(raddr0), .mem_rdata(rdata0), .mem_we(we0), .mem_waddr(waddr0),
    .mem_wdata(wdata0), .busy(busy0), .done(done0), .fill_count(fill0),
    .conflict(conf0), .conflict_row(crow0), .conflict_col(ccol0), .pass_overflow(ovf0)
  );

  trax_autocomplete_engine #(.ROWS(20), .COLS(20), .ADDR_W(9), .MAX_PASSES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .n(n_in), .m(m_in),
    .mem_raddr(raddr1), .mem_rdata(rdata1), .mem_we(we1), .mem_waddr(waddr1),
    .mem_wdata(wdata1), .busy(busy1), .done(done1), .fill_count(fill1),
    .conflict(conf1), .conflict_row(crow1), .conflict_col(ccol1), .pass_overflow(ovf1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Board RAMs: 1-cycle read latency, bench load port writes both boards.
  always @(posedge clk) begin
    if (tb_we) begin
      mem0[tb_waddr] <= tb_wdata;
      mem1[tb_waddr] <= tb_wdata;
    end
    if (we0) mem0[waddr0] <= wdata0;
    if (we1) mem1[waddr1] <= wdata1;
    rdata0  <= mem0[raddr0];
    rdata1  <= mem1[raddr1];
    we_cnt0 <= we_cnt0 + (we0 ? 1 : 0);
    we_cnt1 <= we_cnt1 + (we1 ? 1 : 0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    tb_we = 1'b1;
    for (int a = 0; a < 400; a++) begin
      tb_waddr = 9'(a);
      tb_wdata = 3'b000;
      @(negedge clk);
    end
    tb_we = 1'b0;
  endtask

  task automatic poke(input int r, input int c, input logic [2:0] t);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = 9'(r * 20 + c);
    tb_wdata = t;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Pulse start on instance k; returns cycles from the start edge until done is seen.
  task automatic run_dut(input int k, input int budget, output int cycles);
    @(negedge clk);
    if (k == 0) start0 = 1'b1;
    else        start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    cycles = 1;
    while (((k == 0) ? done0 : done1) == 1'b0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // A fill at (2,2) (forced by plus/white at (2,1),(2,3)) later forces (1,2)
  // together with plus/white at (0,2).
  task automatic load_chain();
    clear_mem();
    poke(0, 2, 3'b010);
    poke(2, 1, 3'b010);
    poke(2, 3, 3'b010);
  endtask

  initial begin
    int cyc;
    int base;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    n_in = 10'd0; m_in = 10'd0;
    tb_we = 1'b0; tb_waddr = 9'd0; tb_wdata = 3'b000;
    repeat (3) @(negedge clk);

    check_val("rst_busy", busy0, 0);
    check_val("rst_done", done0, 0);
    check_val("rst_we", we0, 0);
    check_val("rst_fill", fill0, 0);
    check_val("rst_conflict", conf0, 0);
    check_val("rst_overflow", ovf0, 0);
    check_val("rst_raddr", raddr0, 0);
    rst_n = 1'b1;
    clear_mem();

    // n==0: IDLE -> PEND -> DONE.
    n_in = 10'd0; m_in = 10'd5; base = we_cnt0;
    run_dut(0, 50, cyc);
    check_val("n0_latency", cyc, 2);
    check_val("n0_fill", fill0, 0);
    check_val("n0_writes", we_cnt0 - base, 0);

    // Empty 20x20: 400 cells x 8 cycles, then PEND and DONE.
    n_in = 10'd20; m_in = 10'd20; base = we_cnt0;
    run_dut(0, 4000, cyc);
    check_val("empty_latency", cyc, 400 * 8 + 1 + 1);
    check_val("empty_fill", fill0, 0);
    check_val("empty_writes", we_cnt0 - base, 0);
    @(negedge clk);
    check_val("empty_busy_after", busy0, 0);

    // Two plus/white tiles with a gap: gap becomes plus/white.
    clear_mem();
    poke(5, 5, 3'b010); poke(5, 7, 3'b010);
    n_in = 10'd10; m_in = 10'd10; base = we_cnt0;
    run_dut(0, 3000, cyc);
    // pass0: 98*8+2*3+1 = 791, PEND, pass1: 97*8+3*3 = 785, PEND, DONE
    check_val("pair_latency", cyc, 1579);
    check_val("pair_fill", fill0, 1);
    check_val("pair_writes", we_cnt0 - base, 1);
    check_val("pair_tile", mem0[5 * 20 + 6], 3'b010);
    check_val("pair_overflow", ovf0, 0);

    // Forced chain over two changed passes plus one clean pass.
    load_chain();
    n_in = 10'd6; m_in = 10'd6; base = we_cnt0;
    run_dut(0, 2000, cyc);
    // 274 + PEND + 269 + PEND + 263 + PEND + DONE
    check_val("chain_latency", cyc, 810);
    check_val("chain_fill", fill0, 2);
    check_val("chain_tile_a", mem0[2 * 20 + 2], 3'b010);
    check_val("chain_tile_b", mem0[1 * 20 + 2], 3'b010);
    check_val("chain_overflow", ovf0, 0);

    // Same chain on the 2-pass instance: stops with overflow after pass 1.
    load_chain();
    base = we_cnt1;
    run_dut(1, 2000, cyc);
    check_val("ovf_latency", cyc, 546);
    check_val("ovf_flag", ovf1, 1);
    check_val("ovf_fill", fill1, 2);
    check_val("ovf_writes", we_cnt1 - base, 2);

    // Conflict: (1,2) sees black edges from up, down and left; all else filled.
    clear_mem();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) poke(r, c, 3'b011);
    poke(1, 1, 3'b010); poke(1, 2, 3'b000);
    n_in = 10'd3; m_in = 10'd4; base = we_cnt0;
    run_dut(0, 500, cyc);
    check_val("conf_latency", cyc, 43);
    check_val("conf_flag", conf0, 1);
    check_val("conf_row", crow0, 1);
    check_val("conf_col", ccol0, 2);
    check_val("conf_fill", fill0, 0);
    check_val("conf_writes", we_cnt0 - base, 0);
    check_val("conf_cell_empty", mem0[1 * 20 + 2], 3'b000);

    // Reset during the first WR, then a clean rerun.
    clear_mem();
    poke(5, 5, 3'b010); poke(5, 7, 3'b010);
    n_in = 10'd10; m_in = 10'd10;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; cyc = 1;
    while (!we0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("rstmid_we_seen", we0, 1);
    rst_n = 1'b0;
    #1;
    check_val("rstmid_we", we0, 0);
    check_val("rstmid_busy", busy0, 0);
    check_val("rstmid_fill", fill0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_val("rstmid_no_write", mem0[5 * 20 + 6], 3'b000);
    run_dut(0, 3000, cyc);
    check_val("rerun_latency", cyc, 1579);
    check_val("rerun_fill", fill0, 1);
    check_val("rerun_conflict", conf0, 0);
    check_val("rerun_tile", mem0[5 * 20 + 6], 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
